// File: rtl/dispatch_demux.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_demux
// Description : One-to-N valid/ready demultiplexer. A single input stream is
//               steered to one of N_OUT destination lanes by a per-transaction
//               select. Each lane owns a 2-entry FIFO, so a stalled consumer
//               only back-pressures traffic aimed at its own lane. Selects
//               that name no lane are accepted, discarded and counted.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               flush             - synchronous clear of all lanes
//               in_data/in_sel/in_valid/in_ready - input stream
//               out_data/out_valid/out_ready     - N_OUT output lanes, lane i
//                                   payload at out_data[i*DATA_W +: DATA_W]
//               drop_err          - one-cycle pulse per discarded transaction
//               drop_cnt          - saturating count of discarded transactions
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_demux #(
    parameter int N_OUT  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    drop_err,
    output logic [7:0]              drop_cnt
);

    // Per-lane FIFO state: head is entry 0 and always drives the lane output,
    // tail is entry 1 and only holds data when the lane count is 2.
    logic [1:0]        cnt_q  [N_OUT];
    logic [1:0]        cnt_d  [N_OUT];
    logic [DATA_W-1:0] head_q [N_OUT];
    logic [DATA_W-1:0] head_d [N_OUT];
    logic [DATA_W-1:0] tail_q [N_OUT];
    logic [DATA_W-1:0] tail_d [N_OUT];

    logic              drop_err_q;
    logic              drop_err_d;
    logic [7:0]        drop_cnt_q;
    logic [7:0]        drop_cnt_d;

    logic [N_OUT-1:0]  lane_full;
    logic [N_OUT-1:0]  sel_hit;
    logic [N_OUT-1:0]  push;
    logic [N_OUT-1:0]  pop;
    logic              sel_in_range;
    logic              sel_full;
    logic              accept;
    logic              drop;

    // ------------------------------------------------------------------
    // Lane outputs come straight from registered state.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_lane
            assign out_data[g*DATA_W +: DATA_W] = head_q[g];
            assign out_valid[g]                 = (cnt_q[g] != 2'd0);
            assign lane_full[g]                 = (cnt_q[g] == 2'd2);
        end
    endgenerate

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

    // ------------------------------------------------------------------
    // Select decode and handshake. Decoding the select against every lane
    // index gives both the one-hot push target and the in-range flag, and
    // avoids indexing lane state with a select that may name no lane.
    // ------------------------------------------------------------------
    always_comb begin
        sel_hit  = '0;
        sel_full = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
                sel_full   = lane_full[i];
            end
        end
    end

    assign sel_in_range = |sel_hit;
    // A full lane never passes through, even if its consumer is ready now.
    assign in_ready     = !flush && !sel_full;
    assign accept       = in_valid && in_ready;
    assign push         = accept ? sel_hit : '0;
    assign drop         = accept && !sel_in_range;
    // No pop is committed in a flush cycle.
    assign pop          = out_valid & out_ready & {N_OUT{!flush}};

    // ------------------------------------------------------------------
    // Lane next-state.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            cnt_d[i]  = cnt_q[i];
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            if (flush) begin
                cnt_d[i] = 2'd0;
            end else begin
                case ({push[i], pop[i]})
                    2'b10: begin
                        if (cnt_q[i] == 2'd0) begin
                            head_d[i] = in_data;
                        end else begin
                            tail_d[i] = in_data;
                        end
                        cnt_d[i] = cnt_q[i] + 2'd1;
                    end
                    2'b01: begin
                        head_d[i] = tail_q[i];
                        cnt_d[i]  = cnt_q[i] - 2'd1;
                    end
                    2'b11: begin
                        // Only reachable at count 1: the new data replaces
                        // the departing head and the count is unchanged.
                        head_d[i] = in_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Discard bookkeeping. The counter survives flush.
    // ------------------------------------------------------------------
    always_comb begin
        drop_err_d = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i]  <= 2'd0;
                head_q[i] <= '0;
                tail_q[i] <= '0;
            end
            drop_err_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
            end
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_demux
// Description : Directed self-checking bench for dispatch_demux (N_OUT=4,
//               DATA_W=32, SEL_W=3). Inputs change 1 ns after a rising edge;
//               outputs are sampled there too, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_demux;

    localparam int N_OUT  = 4;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic                    drop_err;
    logic [7:0]              drop_cnt;

    int checks;
    int failures;

    dispatch_demux #(
        .N_OUT (N_OUT),
        .DATA_W(DATA_W),
        .SEL_W (SEL_W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .drop_err (drop_err),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] lane(input int i);
        return out_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '1;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_out_data",  128'(out_data),  128'h0);
        check("rst_drop_err",  128'(drop_err),  128'h0);
        check("rst_drop_cnt",  128'(drop_cnt),  128'h0);
        #5 rst_n = 1'b1;
        tick();

        // ---------------- single transaction to lane 2 ----------------
        drive(1'b1, 3'd2, 32'hDEADBEEF);
        #1 check("t1_in_ready", 128'(in_ready), 128'h1);
        tick();
        drive(1'b0, 3'd0, 32'h0);
        check("t1_out_valid", 128'(out_valid), 128'h4);
        check("t1_lane2",     128'(lane(2)),   128'hDEADBEEF);
        tick();
        check("t1_drained",   128'(out_valid), 128'h0);

        // ---------------- lane 1 back-pressure ----------------
        out_ready = 4'b1101;
        drive(1'b1, 3'd1, 32'h11);
        #1 check("t2_rdy_11", 128'(in_ready), 128'h1);
        tick();
        drive(1'b1, 3'd1, 32'h22);
        #1 check("t2_rdy_22", 128'(in_ready), 128'h1);
        tick();
        drive(1'b1, 3'd1, 32'h33);
        #1 check("t2_rdy_33_full", 128'(in_ready), 128'h0);
        check("t2_lane1_head", 128'(lane(1)), 128'h11);
        // Other lanes stay open while lane 1 is full.
        drive(1'b1, 3'd0, 32'h44);
        #1 check("t2_rdy_lane0", 128'(in_ready), 128'h1);
        tick();
        check("t2_valid_01",  128'(out_valid), 128'h3);
        check("t2_lane0",     128'(lane(0)),   128'h44);
        drive(1'b1, 3'd1, 32'h33);
        out_ready = 4'b1111;
        #1 check("t2_rdy_33_still_full", 128'(in_ready), 128'h0);
        tick();
        check("t2_lane1_22",  128'(lane(1)),   128'h22);
        check("t2_valid_1",   128'(out_valid), 128'h2);
        #1 check("t2_rdy_33_open", 128'(in_ready), 128'h1);
        tick();
        drive(1'b0, 3'd0, 32'h0);
        check("t2_lane1_33",  128'(lane(1)),   128'h33);
        check("t2_valid_33",  128'(out_valid), 128'h2);
        tick();
        check("t2_drained",   128'(out_valid), 128'h0);

        // ---------------- lane 3 push+pop at count 1 ----------------
        out_ready = 4'b0111;
        drive(1'b1, 3'd3, 32'hA);
        tick();
        check("t3_valid_a",   128'(out_valid), 128'h8);
        check("t3_head_a",    128'(lane(3)),   128'hA);
        out_ready = 4'b1111;
        drive(1'b1, 3'd3, 32'hB);
        #1 check("t3_rdy_b",  128'(in_ready),  128'h1);
        tick();
        drive(1'b0, 3'd0, 32'h0);
        check("t3_valid_b",   128'(out_valid), 128'h8);
        check("t3_head_b",    128'(lane(3)),   128'hB);
        tick();
        check("t3_drained",   128'(out_valid), 128'h0);

        // ---------------- out-of-range select, saturation ----------------
        drive(1'b1, 3'd5, 32'h55);
        for (int i = 0; i < 300; i++) begin
            #1 check("t4_rdy", 128'(in_ready), 128'h1);
            tick();
            check("t4_drop_err", 128'(drop_err),  128'h1);
            check("t4_no_valid", 128'(out_valid), 128'h0);
            check("t4_drop_cnt", 128'(drop_cnt),  128'((i + 1 > 255) ? 255 : i + 1));
        end
        drive(1'b0, 3'd0, 32'h0);
        tick();
        check("t4_err_clear", 128'(drop_err), 128'h0);
        check("t4_cnt_sat",   128'(drop_cnt), 128'hFF);

        // ---------------- flush ----------------
        out_ready = 4'b0000;
        drive(1'b1, 3'd0, 32'h100); tick();
        drive(1'b1, 3'd0, 32'h101); tick();
        drive(1'b1, 3'd2, 32'h200); tick();
        drive(1'b1, 3'd2, 32'h201); tick();
        check("t5_filled", 128'(out_valid), 128'h5);
        flush     = 1'b1;
        out_ready = 4'b1111;
        drive(1'b1, 3'd1, 32'h300);
        #1 check("t5_rdy_flush", 128'(in_ready), 128'h0);
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0);
        check("t5_valid_clr",  128'(out_valid), 128'h0);
        check("t5_drop_cnt",   128'(drop_cnt),  128'hFF);
        // Empty lanes keep their last head visible.
        check("t5_lane0_hold", 128'(lane(0)),   128'h100);
        tick();
        check("t5_no_late",    128'(out_valid), 128'h0);

        // ---------------- asynchronous reset mid-cycle ----------------
        out_ready = 4'b0000;
        for (int l = 0; l < N_OUT; l++) begin
            for (int k = 0; k < 2; k++) begin
                drive(1'b1, SEL_W'(l), DATA_W'(32'hC0 + l * 2 + k));
                tick();
            end
        end
        drive(1'b1, 3'd7, 32'h0);
        tick();
        drive(1'b0, 3'd0, 32'h0);
        check("t6_full",     128'(out_valid), 128'hF);
        check("t6_cnt_pre",  128'(drop_cnt),  128'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid",    128'(out_valid), 128'h0);
        check("t6_data",     128'(out_data),  128'h0);
        check("t6_drop_cnt", 128'(drop_cnt),  128'h0);
        check("t6_drop_err", 128'(drop_err),  128'h0);
        #3 rst_n = 1'b1;
        tick();
        check("t6_post",     128'(out_valid), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
